// File: rtl/vga_frame_receiver.sv
// Receive end of the mono VGA link. It recovers pixel coordinates from hsync and vsync,
// qualifies the sync timing into a lock state, and reports lit pixels per frame.
module vga_frame_receiver #(
  parameter int H_TOTAL         = 800,
  parameter int V_TOTAL         = 525,
  parameter int H_ACT_START     = 144,
  parameter int V_ACT_START     = 35,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic        err_sticky
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam int   TO_LIMIT  = 2 * H_TOTAL - 1;
  localparam int   TO_W      = $clog2(2 * H_TOTAL);
  localparam int   GF_W      = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t          state, state_d;
  logic [GF_W-1:0] good_frames, good_frames_d;
  logic            err_set;

  logic [1:0] hs_ff, vs_ff, vid_ff;
  logic       hs_prev, vs_prev, vid_d;
  logic       hs_act, vs_act, hs_edge, vs_edge;

  logic [9:0]      hcount, vcount;
  logic [TO_W-1:0] line_len;
  logic            v_pending, lines_ok;
  logic            frame_start, line_bad, timeout, frame_good, bad_evt;
  logic            in_win, lit_hit;
  logic [18:0]     lit_acc;

  // Synchronizers idle at the inactive sync level so that reset cannot fake an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_ff   <= {2{SYNC_IDLE}};
      vs_ff   <= {2{SYNC_IDLE}};
      vid_ff  <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      vid_d   <= 1'b0;
    end else begin
      hs_ff   <= {hs_ff[0], hsync_in};
      vs_ff   <= {vs_ff[0], vsync_in};
      vid_ff  <= {vid_ff[0], video_in};
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      vid_d   <= vid_ff[1];
    end
  end

  assign hs_act  = hs_ff[1] ^ SYNC_IDLE;
  assign vs_act  = vs_ff[1] ^ SYNC_IDLE;
  assign hs_edge = hs_act & ~hs_prev;
  assign vs_edge = vs_act & ~vs_prev;

  assign frame_start = hs_edge & (v_pending | vs_edge);
  assign line_bad    = hs_edge && (int'(hcount) + 1 != H_TOTAL);
  assign timeout     = !hs_edge && (line_len == TO_W'(TO_LIMIT));
  assign frame_good  = (int'(vcount) + 1 == V_TOTAL) && lines_ok && !line_bad;
  assign bad_evt     = line_bad || timeout || (frame_start && !frame_good);

  // hcount saturates at 1023 and cannot reach 2*H_TOTAL-1, so the stall timeout
  // uses its own wider counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount    <= '0;
      vcount    <= '0;
      line_len  <= '0;
      v_pending <= 1'b0;
      lines_ok  <= 1'b1;
    end else begin
      if (hs_edge) hcount <= '0;
      else if (hcount != '1) hcount <= hcount + 10'd1;
      if (hs_edge) line_len <= '0;
      else if (line_len != '1) line_len <= line_len + TO_W'(1);
      if (frame_start) vcount <= '0;
      else if (hs_edge && vcount != '1) vcount <= vcount + 10'd1;
      if (hs_edge) v_pending <= 1'b0;
      else if (vs_edge) v_pending <= 1'b1;
      if (frame_start) lines_ok <= 1'b1;
      else if (line_bad || timeout) lines_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_UNLOCKED;
      good_frames <= '0;
    end else begin
      state       <= state_d;
      good_frames <= good_frames_d;
    end
  end

  // Line checks only start once acquisition begins, which excludes the partial first line.
  always_comb begin
    state_d       = state;
    good_frames_d = good_frames;
    err_set       = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (frame_start) begin
          state_d       = ST_ACQUIRE;
          good_frames_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (bad_evt) begin
          state_d = ST_UNLOCKED;
        end else if (frame_start) begin
          good_frames_d = good_frames + GF_W'(1);
          if (good_frames_d == GF_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (bad_evt) begin
          err_set = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign locked = (state == ST_LOCKED);

  // vid_d trails the sync path by one flop so the sampled pixel lines up with the
  // registered hcount.
  assign in_win = locked
               && (int'(hcount) >= H_ACT_START) && (int'(hcount) < H_ACT_START + H_ACTIVE)
               && (int'(vcount) >= V_ACT_START) && (int'(vcount) < V_ACT_START + V_ACTIVE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= 1'b0;
    end else begin
      pix_valid <= in_win;
      pix_x     <= in_win ? hcount - 10'(H_ACT_START) : '0;
      pix_y     <= in_win ? vcount - 10'(V_ACT_START) : '0;
      pix_data  <= in_win & vid_d;
    end
  end

  assign lit_hit = pix_valid & pix_data;

  // A lit pixel that coincides with the boundary is counted in the new frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lit_acc    <= '0;
      lit_count  <= '0;
      frame_done <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      frame_done <= frame_start;
      if (frame_start) begin
        lit_count <= lit_acc;
        lit_acc   <= lit_hit ? 19'd1 : 19'd0;
      end else if (lit_hit) begin
        lit_acc <= lit_acc + 19'd1;
      end
      if (err_set) err_sticky <= 1'b1;
    end
  end

endmodule
